// File: rtl/clause_row_loader_pkg.sv
// Shared definitions for the clause-array literal interface.
// - LIT_NONE / LIT_POS / LIT_NEG: 2-bit literal encoding per column, also
//   decoded by the clause array rows.
// - loader_state_t: clause_row_loader FSM states (exposed on state_o).
// - encode_lit: literal sign to 2-bit column code.
package clause_row_loader_pkg;

  localparam logic [1:0] LIT_NONE = 2'b00;
  localparam logic [1:0] LIT_POS  = 2'b10;
  localparam logic [1:0] LIT_NEG  = 2'b01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    CLEAR   = 3'd3,
    DONE    = 3'd4
  } loader_state_t;

  function automatic logic [1:0] encode_lit(input logic sign);
    return sign ? LIT_NEG : LIT_POS;
  endfunction

endpackage

// File: rtl/clause_row_loader_lit_pack_buf.sv
// Packing register for one clause: NUM_LITS columns of 2-bit literals.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - clear the whole vector (wins over wr)
//   wr        - write lit into column col
//   col, lit  - column index and encoded literal
//   vec       - packed vector, column k at bits [2k+1:2k]
//   dup       - combinational: the column being written is already non-zero
module lit_pack_buf
  import clause_row_loader_pkg::*;
#(
  parameter int NUM_LITS   = 8,
  parameter int WIDTH_VIDX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr,
  input  logic [WIDTH_VIDX-1:0] col,
  input  logic [1:0]            lit,
  output logic [NUM_LITS*2-1:0] vec,
  output logic                  dup
);

  // {col, 1'b0} is 2*col without widening into a 32-bit expression
  assign dup = wr && (vec[{col, 1'b0} +: 2] != LIT_NONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec <= '0;
    end else if (clr) begin
      vec <= '0;
    end else if (wr) begin
      vec[{col, 1'b0} +: 2] <= lit;
    end
  end

endmodule

// File: rtl/clause_row_loader.sv
// Clause row loader: packs a literal stream into one clause vector per row,
// writes each row once, then zero-writes every remaining row so stale clauses
// of the previous bin are wiped.
// Handshake: a literal beat transfers on a rising edge where lit_valid_i and
// lit_ready_o are both 1; lit_ready_o does not depend on lit_valid_i and is
// only 1 in COLLECT.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   start_i           - begin a load (IDLE only), num_clause_i sampled with it
//   lit_*             - literal beat stream (column, sign, last-of-clause)
//   wr_o, wr_row_o    - row write strobe and one-hot row select
//   lit_o             - packed literal vector for the selected row
//   busy_o, done_o    - load in progress / one-cycle completion pulse
//   err_dup_o         - sticky: a column repeated within one clause
//   state_o           - current FSM state (debug)
module clause_row_loader
  import clause_row_loader_pkg::*;
#(
  parameter int NUM_LITS    = 8,
  parameter int NUM_CLAUSES = 8,
  parameter int WIDTH_VIDX  = 3,
  parameter int WIDTH_CIDX  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [WIDTH_CIDX:0]    num_clause_i,
  input  logic                   lit_valid_i,
  output logic                   lit_ready_o,
  input  logic [WIDTH_VIDX-1:0]  lit_var_i,
  input  logic                   lit_sign_i,
  input  logic                   lit_last_i,
  output logic                   wr_o,
  output logic [NUM_CLAUSES-1:0] wr_row_o,
  output logic [NUM_LITS*2-1:0]  lit_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_dup_o,
  output loader_state_t          state_o
);

  localparam logic [WIDTH_CIDX:0]    N_MAX    = (WIDTH_CIDX+1)'(NUM_CLAUSES);
  localparam logic [WIDTH_CIDX:0]    LAST_ROW = (WIDTH_CIDX+1)'(NUM_CLAUSES-1);
  localparam logic [NUM_CLAUSES-1:0] ROW_ONE  = {{(NUM_CLAUSES-1){1'b0}}, 1'b1};

  loader_state_t state, state_n;

  // row counter is one bit wider than a row index so it can reach N_MAX
  logic [WIDTH_CIDX:0]   row, row_inc, n, n_clip;
  logic                  accept, buf_clr, dup;
  logic [NUM_LITS*2-1:0] buf_vec;

  assign accept  = lit_valid_i && lit_ready_o;
  assign row_inc = row + 1'b1;
  assign n_clip  = (num_clause_i > N_MAX) ? N_MAX : num_clause_i;
  assign state_o = state;

  lit_pack_buf #(
    .NUM_LITS   (NUM_LITS),
    .WIDTH_VIDX (WIDTH_VIDX)
  ) u_buf (
    .clk (clk),
    .rst (rst),
    .clr (buf_clr),
    .wr  (accept),
    .col (lit_var_i),
    .lit (encode_lit(lit_sign_i)),
    .vec (buf_vec),
    .dup (dup)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    buf_clr = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          buf_clr = 1'b1;
          state_n = (n_clip == '0) ? CLEAR : COLLECT;
        end
      end
      COLLECT: begin
        if (accept && lit_last_i) state_n = WRITE;
      end
      WRITE: begin
        buf_clr = 1'b1;
        if (row_inc == n) state_n = (n == N_MAX) ? DONE : CLEAR;
        else              state_n = COLLECT;
      end
      CLEAR: begin
        if (row == LAST_ROW) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs. ready/busy are taken from the next state so they line
  // up with the state register; write strobes appear the cycle after
  // WRITE/CLEAR, done_o the cycle after DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row         <= '0;
      n           <= '0;
      err_dup_o   <= 1'b0;
      wr_o        <= 1'b0;
      wr_row_o    <= '0;
      lit_o       <= '0;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
      lit_ready_o <= 1'b0;
    end else begin
      wr_o        <= 1'b0;
      wr_row_o    <= '0;
      done_o      <= 1'b0;
      busy_o      <= (state_n != IDLE);
      lit_ready_o <= (state_n == COLLECT);
      case (state)
        IDLE: begin
          if (start_i) begin
            n         <= n_clip;
            row       <= '0;
            err_dup_o <= 1'b0;
          end
        end
        COLLECT: begin
          if (dup) err_dup_o <= 1'b1;
        end
        WRITE: begin
          wr_o     <= 1'b1;
          wr_row_o <= ROW_ONE << row;
          lit_o    <= buf_vec;
          row      <= row_inc;
        end
        CLEAR: begin
          wr_o     <= 1'b1;
          wr_row_o <= ROW_ONE << row;
          lit_o    <= '0;
          row      <= row_inc;
        end
        DONE:    done_o <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clause_row_loader.sv
module tb_clause_row_loader;

  localparam int NL = 8;
  localparam int NC = 8;
  localparam int W  = NC + NL*2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start_i = 1'b0;
  logic [3:0]      num_clause_i = '0;
  logic            lit_valid_i = 1'b0;
  logic            lit_ready_o;
  logic [2:0]      lit_var_i = '0;
  logic            lit_sign_i = 1'b0;
  logic            lit_last_i = 1'b0;
  logic            wr_o;
  logic [NC-1:0]   wr_row_o;
  logic [NL*2-1:0] lit_o;
  logic            busy_o, done_o, err_dup_o;
  clause_row_loader_pkg::loader_state_t state_o;

  clause_row_loader dut (
    .clk(clk), .rst(rst), .start_i(start_i), .num_clause_i(num_clause_i),
    .lit_valid_i(lit_valid_i), .lit_ready_o(lit_ready_o), .lit_var_i(lit_var_i),
    .lit_sign_i(lit_sign_i), .lit_last_i(lit_last_i), .wr_o(wr_o),
    .wr_row_o(wr_row_o), .lit_o(lit_o), .busy_o(busy_o), .done_o(done_o),
    .err_dup_o(err_dup_o), .state_o(state_o)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int last_wr_cyc = 0;
  logic [W-1:0] exp_q[$];

  // scoreboard: every row write is popped against the expected queue
  always @(negedge clk) begin
    if (rst && wr_o) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL wr_unexpected: got row=%h lit=%h, required no write", wr_row_o, lit_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({wr_row_o, lit_o} !== e)
          $display("FAIL wr_data: got row=%h lit=%h, required row=%h lit=%h",
                   wr_row_o, lit_o, e[W-1:NL*2], e[NL*2-1:0]);
        else pass_cnt++;
      end
      last_wr_cyc = cyc;
    end
    if (rst && (state_o == clause_row_loader_pkg::WRITE || state_o == clause_row_loader_pkg::CLEAR)) begin
      chk_cnt++;
      if (lit_ready_o !== 1'b0)
        $display("FAIL ready_in_write: got %b in state %0d, required 0", lit_ready_o, state_o);
      else pass_cnt++;
    end
  end

  // ---------------- model helpers ----------------
  function automatic logic [1:0] enc(input bit s);
    return s ? 2'b01 : 2'b10;
  endfunction

  task automatic push_row(input int r, input logic [NL*2-1:0] v);
    logic [NC-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    exp_q.push_back({oh, v});
  endtask

  task automatic push_clears(input int from);
    for (int r = from; r < NC; r++) push_row(r, '0);
  endtask

  // ---------------- drivers (called at posedge+1) ----------------
  task automatic do_start(input int n);
    start_i = 1'b1;
    num_clause_i = 4'(n);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send_beat(input int v, input bit s, input bit last, input int gap_max);
    bit r;
    int gaps;
    bit got;
    gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    for (int g = 0; g < gaps; g++) begin
      lit_valid_i = 1'b0;
      start_i = 1'($urandom_range(0, 1));
      num_clause_i = 4'd5;
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    lit_valid_i = 1'b1;
    lit_var_i = 3'(v);
    lit_sign_i = s;
    lit_last_i = last;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      r = lit_ready_o;
      @(posedge clk); #1;
      got = r;
    end
    lit_valid_i = 1'b0;
    lit_last_i = 1'b0;
    if (!got) begin
      chk_cnt++;
      $display("FAIL beat_timeout: got no accept for var %0d, required accept", v);
    end
  endtask

  task automatic wait_done(output bit ready_seen);
    bit seen;
    seen = 1'b0;
    ready_seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      if (lit_ready_o) ready_seen = 1'b1;
      if (done_o) seen = 1'b1;
    end
    chk_cnt++;
    if (!seen) $display("FAIL done_timeout: got no done_o, required pulse");
    else pass_cnt++;
    if (seen) begin
      chk_cnt++;
      if (cyc - last_wr_cyc != 1)
        $display("FAIL done_latency: got %0d cycles after last write, required 1", cyc - last_wr_cyc);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (done_o !== 1'b0 || busy_o !== 1'b0)
        $display("FAIL done_pulse: got done=%b busy=%b, required 0 0", done_o, busy_o);
      else pass_cnt++;
    end
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL writes_missing: got %0d pending, required 0", exp_q.size());
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic check_dup(input logic exp);
    chk_cnt++;
    if (err_dup_o !== exp) $display("FAIL err_dup: got %b, required %b", err_dup_o, exp);
    else pass_cnt++;
  endtask

  task automatic check_all_zero(input string tag);
    chk_cnt++;
    if ({lit_ready_o, wr_o, wr_row_o, lit_o, busy_o, done_o, err_dup_o} !== '0)
      $display("FAIL %s: got rdy=%b wr=%b row=%h lit=%h busy=%b done=%b dup=%b, required all 0",
               tag, lit_ready_o, wr_o, wr_row_o, lit_o, busy_o, done_o, err_dup_o);
    else pass_cnt++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset_values");
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("after_reset_idle");
  endtask

  task automatic test_single;
    bit rs;
    push_row(0, 16'h0480);   // var3 positive, var5 negative
    push_clears(1);
    do_start(1);
    chk_cnt++;
    if (busy_o !== 1'b1 || lit_ready_o !== 1'b1)
      $display("FAIL start_busy: got busy=%b rdy=%b, required 1 1", busy_o, lit_ready_o);
    else pass_cnt++;
    send_beat(3, 0, 0, 0);
    send_beat(5, 1, 1, 0);
    wait_done(rs);
    check_dup(1'b0);
  endtask

  task automatic test_dup;
    bit rs;
    push_row(0, 16'h0010);   // var2 last written negative
    push_clears(1);
    do_start(1);
    send_beat(2, 0, 0, 0);
    send_beat(2, 1, 1, 0);
    wait_done(rs);
    check_dup(1'b1);
  endtask

  task automatic test_full(input int num);
    bit rs;
    for (int r = 0; r < NC; r++) push_row(r, 16'(32'h2 << (2*r)));
    do_start(num);
    check_dup(1'b0);          // cleared by the start
    for (int r = 0; r < NC; r++) send_beat(r, 0, 1, 0);
    wait_done(rs);
  endtask

  task automatic test_zero;
    bit rs;
    push_clears(0);
    do_start(0);
    wait_done(rs);
    chk_cnt++;
    if (rs) $display("FAIL zero_ready: got lit_ready_o=1, required 0");
    else pass_cnt++;
  endtask

  task automatic test_gaps;
    int bv[9] = '{1, 4, 7, 0, 2, 3, 6, 5, 6};
    bit bs[9] = '{0, 1, 0, 1, 0, 0, 1, 0, 0};
    bit bl[9] = '{0, 0, 1, 1, 0, 0, 0, 0, 1};
    bit rs;
    for (int mode = 0; mode < 2; mode++) begin
      logic [NL*2-1:0] v;
      int row;
      v = '0;
      row = 0;
      for (int i = 0; i < 9; i++) begin
        v[2*bv[i] +: 2] = enc(bs[i]);
        if (bl[i]) begin
          push_row(row, v);
          row++;
          v = '0;
        end
      end
      push_clears(row);
      do_start(3);
      for (int i = 0; i < 9; i++) send_beat(bv[i], bs[i], bl[i], mode * 3);
      wait_done(rs);
      check_dup(1'b1);        // var6 appears twice in the last clause
    end
  endtask

  task automatic test_reset_mid;
    bit rs;
    do_start(2);
    send_beat(6, 1, 0, 0);
    send_beat(1, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_load");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    push_row(0, 16'h0002);
    push_clears(1);
    do_start(1);
    send_beat(0, 0, 1, 0);
    wait_done(rs);
  endtask

  initial begin
    test_reset;
    test_single;
    test_dup;
    test_full(8);
    test_full(15);
    test_zero;
    test_gaps;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/clause_row_loader.md
Name: clause_row_loader

Overview:
- Writer side of the clause-array literal interface. Receives a stream of literals (variable column, sign, end-of-clause) and packs each clause into a NUM_LITS*2 literal vector.
- Writes one clause row at a time through the row's wr_i/lit_i inputs.
- After the last requested clause, writes all-zero vectors into every remaining row, so stale clauses from the previous bin never reach clausesat/cclause logic.
- Sits between the bin fetch unit and the clause array rows.

Parameters:
- NUM_LITS, 8, literal columns per clause row (power of 2, ≥2).
- NUM_CLAUSES, 8, clause rows in the array (power of 2, ≥2).
- WIDTH_VIDX, 3, column index width = log2(NUM_LITS).
- WIDTH_CIDX, 3, row index width = log2(NUM_CLAUSES).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- start_i  in  1  begin a load; sampled only in IDLE.
- num_clause_i  in  WIDTH_CIDX+1  clauses to load; sampled with start_i.
- lit_valid_i  in  1  literal beat valid.
- lit_ready_o  out  1  loader accepts a beat.
- lit_var_i  in  WIDTH_VIDX  literal column inside the bin.
- lit_sign_i  in  1  1 = negated literal.
- lit_last_i  in  1  beat is the clause's final literal.
- wr_o  out  1  row write strobe, drives the selected row's wr_i.
- wr_row_o  out  NUM_CLAUSES  one-hot row select.
- lit_o  out  NUM_LITS*2  packed literal vector, drives lit_i.
- busy_o  out  1  load in progress.
- done_o  out  1  one-cycle pulse when the load completes.
- err_dup_o  out  1  sticky flag: a column was repeated within one clause.

Behaviour:
- Literal encoding per column (2 bits, column k at bits [2k+1:2k]): 2'b00 = absent, 2'b10 = positive, 2'b01 = negative.
- Reset (rst=0, asynchronous) values:
  - FSM goes to IDLE.
  - lit_ready_o, wr_o, done_o, busy_o, err_dup_o = 0.
  - wr_row_o and lit_o = 0.
  - Row counter and packing buffer = 0.
- Reset mid-load abandons the load. Rows already written are not cleared.
- FSM states: IDLE, COLLECT, WRITE, CLEAR, DONE.
- IDLE:
  - On start_i, latch n = min(num_clause_i, NUM_CLAUSES), clear row counter, buffer and err_dup_o.
  - Go to CLEAR if n==0, otherwise to COLLECT.
- COLLECT:
  - lit_ready_o=1. A beat is accepted when lit_valid_i & lit_ready_o.
  - On accept, buffer[lit_var_i] <= encoded sign.
  - If that column is already non-zero, the new value overwrites it and err_dup_o is set (stays set until the next start).
  - On an accepted beat with lit_last_i=1, go to WRITE; lit_ready_o is 0 from the next cycle.
- WRITE (exactly one cycle):
  - wr_o=1, wr_row_o = 1<<row, lit_o = buffer, all registered.
  - Next cycle: buffer cleared, row incremented.
  - If the incremented row == n: go to CLEAR, or to DONE if n==NUM_CLAUSES.
  - Otherwise go back to COLLECT.
- CLEAR:
  - One write per cycle with wr_o=1, wr_row_o = 1<<row, lit_o = 0, row++.
  - After writing row NUM_CLAUSES-1, go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Outputs are registered.
  - The first accepted literal of a clause lands on lit_o no sooner than 2 cycles after acceptance.
  - A clause of L beats with no valid gaps takes L+1 cycles.
- Outside WRITE and CLEAR: wr_o=0 and wr_row_o=0. lit_o holds its last value; rows ignore it.
- busy_o=1 in every state except IDLE.
- start_i outside IDLE is ignored.
- lit_valid_i outside COLLECT is not accepted (ready=0).
- A zero-width clause cannot occur: each clause carries at least the beat marked last.
- Row counter is WIDTH_CIDX+1 bits. Compare against n and NUM_CLAUSES, never let it wrap.

Decomposition:
- Shared package (e.g. sat_pkg) holds:
  - literal encoding constants LIT_NONE, LIT_POS, LIT_NEG;
  - the loader state enum;
  - an encode function (sign → 2-bit literal).
- The clause array rows decode lit_i with the same constants.
- One natural sub-module: lit_pack_buf. It holds the NUM_LITS*2 packing register with column write, duplicate detect and clear.

Test Plan:
- Reset, start with n=1, beats (var3,+), (var5,−,last) → one wr_o pulse with wr_row_o=8'h01 and lit_o bits[7:6]=2'b10, bits[11:10]=2'b01, others 0. Then 7 CLEAR writes to rows 1..7 with lit_o=0, done_o pulse, err_dup_o=0.
- n=8, one single-literal clause per row (row r gets var r, +) → wr_row_o walks 8'h01..8'h80, no CLEAR writes, done_o one cycle after the row-7 write.
- n=0 → 8 consecutive zero writes to rows 0..7, no lit_ready_o, then done_o.
- Duplicate: beats (var2,+), (var2,−,last) → bits[5:4]=2'b01 on lit_o, err_dup_o=1 until the next start_i clears it.
- Random gaps in lit_valid_i plus start_i pulsed mid-load → packed vectors unchanged versus the gap-free run, the mid-load start is ignored, no beat accepted in WRITE/CLEAR.
- rst low during COLLECT after 2 beats → all outputs 0 immediately. A fresh start with n=1 produces a clean vector with no leftover bits.
